tx_enable_arb: RTL and testbench

Parametrised, multi-channel successor to the single-requester UART transmit-enable controller. It arbitrates round-robin among `NUM_CH` requesters sharing one UART transmitter. It aligns the start of each character to a rising edge of the baud clock and holds `enableOut` until the transmitter reports `charSent`. It sits between the per-source transmit-request logic and the shared UART shifter.

---
 rtl/tx_enable_pkg.sv | 20 ++
 rtl/tx_enable_arb_rr_pick.sv | 49 ++++
 rtl/tx_enable_arb.sv | 196 +++++++++++++++++++
 tb/tb_tx_enable_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_enable_pkg.sv
// ---------------------------------------------------------------------------
// tx_enable_pkg
// Shared definitions for the multi-channel UART transmit-enable arbiter.
//   tx_state_t       : arbiter FSM state encoding
//   DEFAULT_TIMEOUT  : default SEND abort limit in clk cycles (only used when
//                      TX_ENABLE_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package tx_enable_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        ARM     = 3'd2,
        SEND    = 3'd3,
        RELEASE = 3'd4
    } tx_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 20000;

endpackage

// File: rtl/tx_enable_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first asserted request
// searching upward from ptr, wrapping from NUM_CH-1 back to 0.
// Ports:
//   req   in  NUM_CH          request vector
//   ptr   in  $clog2(NUM_CH)  search start index (must be < NUM_CH)
//   valid out 1               any request asserted
//   idx   out $clog2(NUM_CH)  index of selected request (meaningful when valid)
// ---------------------------------------------------------------------------
module rr_pick
    import tx_enable_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NUM_CH)-1:0] idx
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    // rot[k] is the request of channel (ptr + k) mod NUM_CH, so the lowest
    // set bit of rot is the round-robin winner.
    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  rot_src [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
        logic [SEL_W:0] pos;
        assign pos          = {1'b0, ptr} + (SEL_W + 1)'(gi);
        assign rot_src[gi]  = (pos >= NUM_CH_W) ? SEL_W'(pos - NUM_CH_W)
                                                : pos[SEL_W-1:0];
        assign rot[gi]      = req[rot_src[gi]];
    end

    always_comb begin
        valid = |rot;
        idx   = rot_src[0];
        // Descending scan: the last hit written is the lowest offset.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = rot_src[k];
            end
        end
    end

endmodule

// File: rtl/tx_enable_arb.sv
// ---------------------------------------------------------------------------
// tx_enable_arb
// Round-robin arbiter letting NUM_CH requesters share one UART transmitter.
// Each character start is aligned to a genuine rising edge of the baud clock
// and enableOut is held until the transmitter reports charSent.
//
// Optional feature macro: TX_ENABLE_TIMEOUT_EN
//   defined   : SEND aborts after TIMEOUT cycles without charSent, pulsing
//               timeoutErr on the owner's bit (TIMEOUT parameter and
//               timeoutErr port exist only in this build)
//   undefined : SEND waits indefinitely for charSent
//
// Ports:
//   clk        in  1       system clock, rising edge
//   reset      in  1       asynchronous active-low reset
//   enableIn   in  NUM_CH  per-channel request level
//   clk9600    in  1       baud clock, asynchronous to clk
//   charSent   in  1       transmitter done strobe
//   enableOut  out 1       transmit enable to the shared shifter
//   grant      out NUM_CH  one-hot current owner, zero when idle
//   selCh      out log2    index of current or last owner
//   done       out NUM_CH  one-cycle pulse on owner's bit at completion
//   busy       out 1       high in every state except IDLE
//   timeoutErr out NUM_CH  one-cycle pulse on abort (timeout build only)
// ---------------------------------------------------------------------------
module tx_enable_arb
    import tx_enable_pkg::*;
#(
    parameter int NUM_CH = 4
`ifdef TX_ENABLE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enableIn,
    input  logic                      clk9600,
    input  logic                      charSent,
    output logic                      enableOut,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] selCh,
    output logic [NUM_CH-1:0]         done,
    output logic                      busy
`ifdef TX_ENABLE_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]         timeoutErr
`endif
);

    localparam int SEL_W = $clog2(NUM_CH);

    tx_state_t         state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [NUM_CH-1:0] grant_reg, grant_next;
    logic [NUM_CH-1:0] done_reg, done_next;
    logic              baud_meta_reg, baud_sync_reg;

    logic              pick_valid;
    logic [SEL_W-1:0]  pick_idx;
    logic              owner_req;
    logic [NUM_CH-1:0] sel_onehot;

`ifdef TX_ENABLE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NUM_CH-1:0] tmo_reg, tmo_next;
`endif

    // Two-flop synchronizer for the asynchronous baud clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_meta_reg <= 1'b0;
            baud_sync_reg <= 1'b0;
        end else begin
            baud_meta_reg <= clk9600;
            baud_sync_reg <= baud_meta_reg;
        end
    end

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req    (enableIn),
        .ptr    (rr_ptr_reg),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign owner_req  = enableIn[sel_reg];
    assign sel_onehot = NUM_CH'(1) << sel_reg;

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        done_next   = '0;
`ifdef TX_ENABLE_TIMEOUT_EN
        cnt_next    = cnt_reg;
        tmo_next    = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    sel_next   = pick_idx;
                    grant_next = NUM_CH'(1) << pick_idx;
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (!owner_req) begin
                    grant_next = '0;
                    state_next = IDLE;
                end else if (!baud_sync_reg) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                // Withdrawal beats a coincident baud edge.
                if (!owner_req) begin
                    grant_next = '0;
                    state_next = IDLE;
                end else if (baud_sync_reg) begin
                    state_next = SEND;
`ifdef TX_ENABLE_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            SEND: begin
                if (charSent) begin
                    done_next  = sel_onehot;
                    state_next = RELEASE;
`ifdef TX_ENABLE_TIMEOUT_EN
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th SEND cycle with no completion.
                    tmo_next   = sel_onehot;
                    state_next = RELEASE;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
`endif
                end
            end
            RELEASE: begin
                if (!owner_req) begin
                    grant_next  = '0;
                    rr_ptr_next = (sel_reg == SEL_W'(NUM_CH - 1)) ? '0
                                                                  : sel_reg + 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            done_reg   <= '0;
`ifdef TX_ENABLE_TIMEOUT_EN
            cnt_reg    <= '0;
            tmo_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
            done_reg   <= done_next;
`ifdef TX_ENABLE_TIMEOUT_EN
            cnt_reg    <= cnt_next;
            tmo_reg    <= tmo_next;
`endif
        end
    end

    // Moore decodes straight off the state register, so an asynchronous
    // reset drops them immediately.
    assign enableOut = (state_reg == SEND);
    assign busy      = (state_reg != IDLE);
    assign grant     = grant_reg;
    assign selCh     = sel_reg;
    assign done      = done_reg;
`ifdef TX_ENABLE_TIMEOUT_EN
    assign timeoutErr = tmo_reg;
`endif

endmodule

// File: tb/tb_tx_enable_arb.sv
// ---------------------------------------------------------------------------
// tb_tx_enable_arb
// Self-checking bench for tx_enable_arb (NUM_CH = 4). A transaction-level
// model predicts outputs each cycle; directed scenarios add literal checks.
// Build with TX_ENABLE_TIMEOUT_EN to also exercise the abort path.
// ---------------------------------------------------------------------------
module tb_tx_enable_arb;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int TMO = 10;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          clk9600  = 1'b0;
    logic          charSent = 1'b0;
    logic [N-1:0]  enableIn = '0;
    logic          enableOut;
    logic          busy;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [SW-1:0] selCh;
`ifdef TX_ENABLE_TIMEOUT_EN
    logic [N-1:0]  timeoutErr;
`endif

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rise_cyc = 0;

    tx_enable_arb #(
        .NUM_CH (N)
`ifdef TX_ENABLE_TIMEOUT_EN
        , .TIMEOUT (TMO)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enableIn   (enableIn),
        .clk9600    (clk9600),
        .charSent   (charSent),
        .enableOut  (enableOut),
        .grant      (grant),
        .selCh      (selCh),
        .done       (done),
        .busy       (busy)
`ifdef TX_ENABLE_TIMEOUT_EN
        , .timeoutErr (timeoutErr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running baud clock: toggles every 50 clk cycles.
    initial begin
        forever begin
            repeat (50) @(negedge clk);
            clk9600 = ~clk9600;
            if (clk9600) rise_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: channel holding the transmitter (-1 = nobody)
    // seen_low: baud observed low since grant; sending: enable phase;
    // finished: char over, waiting for owner to drop its request.
    int m_owner = -1, m_last = 0, m_ptr = 0, m_done_ch = -1, m_tmo_ch = -1;
    int m_send_cycles = 0;
    bit m_seen_low = 0, m_sending = 0, m_finished = 0;
    bit m_h1 = 0, m_h2 = 0;

    function automatic int rr_choose(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= -1; m_last <= 0; m_ptr <= 0; m_done_ch <= -1; m_tmo_ch <= -1;
            m_seen_low <= 0; m_sending <= 0; m_finished <= 0; m_send_cycles <= 0;
            m_h1 <= 0; m_h2 <= 0;
        end else begin
            m_h1 <= clk9600;
            m_h2 <= m_h1;
            m_done_ch <= -1;
            m_tmo_ch  <= -1;
            if (m_owner < 0) begin
                if (rr_choose(enableIn, m_ptr) >= 0) begin
                    m_owner    <= rr_choose(enableIn, m_ptr);
                    m_last     <= rr_choose(enableIn, m_ptr);
                    m_seen_low <= 0;
                    m_sending  <= 0;
                    m_finished <= 0;
                end
            end else if (m_finished) begin
                if (!enableIn[m_owner]) begin
                    m_ptr   <= (m_owner + 1) % N;
                    m_owner <= -1;
                end
            end else if (m_sending) begin
                if (charSent) begin
                    m_done_ch  <= m_owner;
                    m_sending  <= 0;
                    m_finished <= 1;
`ifdef TX_ENABLE_TIMEOUT_EN
                end else if (m_send_cycles + 1 >= TMO) begin
                    m_tmo_ch   <= m_owner;
                    m_sending  <= 0;
                    m_finished <= 1;
`endif
                end else begin
                    m_send_cycles <= m_send_cycles + 1;
                end
            end else begin
                if (!enableIn[m_owner]) begin
                    m_owner <= -1;
                end else if (!m_seen_low) begin
                    if (!m_h2) m_seen_low <= 1;
                end else if (m_h2) begin
                    m_sending     <= 1;
                    m_send_cycles <= 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_enableOut", 32'(enableOut), 32'(m_sending));
        chk("cyc_busy", 32'(busy), 32'(m_owner >= 0));
        chk("cyc_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("cyc_selCh", 32'(selCh), 32'(m_last));
        chk("cyc_done", 32'(done), (m_done_ch >= 0) ? (32'd1 << m_done_ch) : 32'd0);
`ifdef TX_ENABLE_TIMEOUT_EN
        chk("cyc_timeoutErr", 32'(timeoutErr), (m_tmo_ch >= 0) ? (32'd1 << m_tmo_ch) : 32'd0);
`endif
    end

    // ---------------- bounded waits ----------------
    task automatic wait_eo(input string name);
        int t = 0;
        while (!enableOut && t < 400) begin @(negedge clk); t++; end
        if (!enableOut) chk({name, "_eo_timeout"}, 32'(enableOut), 32'd1);
    endtask

    task automatic wait_grant(input string name);
        int t = 0;
        while (grant == '0 && t < 400) begin @(negedge clk); t++; end
        if (grant == '0) chk({name, "_grant_timeout"}, 32'(grant), 32'd1);
    endtask

    task automatic wait_baud_fall(input string name);
        int t = 0;
        while (!clk9600 && t < 200) begin @(negedge clk); t++; end
        while (clk9600 && t < 400) begin @(negedge clk); t++; end
        if (clk9600) chk({name, "_baud_timeout"}, 32'(clk9600), 32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int ch;
        logic [N-1:0] oh;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_enableOut", 32'(enableOut), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_selCh", 32'(selCh), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single channel
        enableIn = 4'b0010;
        @(negedge clk);
        chk("A_grant", 32'(grant), 32'h2);
        chk("A_selCh", 32'(selCh), 32'd1);
        wait_eo("A");
        chk("A_eo_latency", 32'(cyc - rise_cyc), 32'd3);
        repeat (4) @(negedge clk);
        charSent = 1'b1;
        @(negedge clk);
        charSent = 1'b0;
        chk("A_eo_fall", 32'(enableOut), 32'd0);
        chk("A_done", 32'(done), 32'h2);
        @(negedge clk);
        chk("A_done_once", 32'(done), 32'd0);
        chk("A_grant_held", 32'(grant), 32'h2);
        enableIn = '0;
        @(negedge clk);
        chk("A_idle_busy", 32'(busy), 32'd0);
        chk("A_idle_grant", 32'(grant), 32'd0);

        // charSent in IDLE is ignored
        charSent = 1'b1;
        @(negedge clk);
        charSent = 1'b0;
        chk("B_idle_done", 32'(done), 32'd0);
        chk("B_idle_busy", 32'(busy), 32'd0);

        // Cancel in ARM (rrPtr is 2 after channel 1 finished)
        wait_baud_fall("C");
        enableIn = 4'b0100;
        @(negedge clk);
        chk("C_grant", 32'(grant), 32'h4);
        repeat (6) @(negedge clk);
        charSent = 1'b1;
        @(negedge clk);
        charSent = 1'b0;
        chk("C_arm_done", 32'(done), 32'd0);
        chk("C_arm_eo", 32'(enableOut), 32'd0);
        enableIn = '0;
        @(negedge clk);
        chk("C_cancel_busy", 32'(busy), 32'd0);
        chk("C_cancel_grant", 32'(grant), 32'd0);
        enableIn = 4'b1111;
        @(negedge clk);
        chk("C_ptr_kept", 32'(selCh), 32'd2);

        // Reset mid-SEND
        wait_eo("E");
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("E_eo_async", 32'(enableOut), 32'd0);
        chk("E_grant_async", 32'(grant), 32'd0);
        chk("E_busy_async", 32'(busy), 32'd0);
        enableIn = '0;
        @(negedge clk);
        reset = 1'b1;
        chk("E_selCh_after", 32'(selCh), 32'd0);

        // All four channels held: order 0,1,2,3,0
        enableIn = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant("D");
            ch = 0;
            for (int k = 0; k < N; k++) if (grant[k]) ch = k;
            order[i] = ch;
            wait_eo("D");
            repeat (2) @(negedge clk);
            charSent = 1'b1;
            @(negedge clk);
            charSent = 1'b0;
            oh = '0;
            oh[ch] = 1'b1;
            chk("D_done", 32'(done), 32'(oh));
            enableIn[ch] = 1'b0;
            @(negedge clk);
            chk("D_gap_busy", 32'(busy), 32'd0);
            enableIn[ch] = 1'b1;
        end
        for (int i = 0; i < 5; i++) chk("D_order", 32'(order[i]), 32'(exp_order[i]));
        enableIn = '0;
        repeat (3) @(negedge clk);
        chk("D_end_busy", 32'(busy), 32'd0);

`ifdef TX_ENABLE_TIMEOUT_EN
        begin
            int hold = 0;
            enableIn = 4'b0001;
            wait_eo("F");
            while (enableOut && hold < 50) begin @(negedge clk); hold++; end
            chk("F_send_cycles", 32'(hold), 32'(TMO));
            chk("F_timeoutErr", 32'(timeoutErr), 32'h1);
            chk("F_no_done", 32'(done), 32'd0);
            enableIn = '0;
            repeat (3) @(negedge clk);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
